seg_refresh_scheduler: RTL and testbench

Time-multiplexing scheduler for the seven-segment display. It derives a refresh tick from the single system clock with a programmable prescaler, so no ripple-divided clocks are needed. On each tick it hands the shared segment bus to the next enabled digit in round-robin order, and it inserts a blanking dead-time between digits to prevent ghosting. It sits between the board clock and the segment-data mux: `sel` drives the digit-data mux and `anode` drives the display.

---
 rtl/seg_refresh_scheduler.sv | 174 +++++++++++++++++
 tb/tb_seg_refresh_scheduler.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_refresh_scheduler.sv
// seg_refresh_scheduler
// Time-multiplexes a shared seven-segment bus across NUM_DIGITS digits.
// A programmable prescaler on the system clock produces refresh ticks. Each
// tick hands the bus to the next enabled digit in round-robin order. Every
// advance is followed by a blanking dead-time with all anodes off, which
// keeps the outgoing digit from ghosting onto the incoming one.
module seg_refresh_scheduler #(
  parameter int                    NUM_DIGITS  = 8,
  parameter int                    SEL_W       = $clog2(NUM_DIGITS),
  parameter int                    PRESCALE_W  = 20,
  parameter logic [PRESCALE_W-1:0] DEFAULT_DIV = 20'd99999,
  parameter int                    BLANK_CYC   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [NUM_DIGITS-1:0] digit_en,
  input  logic [PRESCALE_W-1:0] div_in,
  input  logic                  div_load,
  output logic                  div_ack,
  output logic [SEL_W-1:0]      sel,
  output logic [NUM_DIGITS-1:0] anode,
  output logic                  tick,
  output logic                  frame
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_t;

  // The blank counter is loaded with the number of blank cycles still to
  // come after the tick cycle itself.
  localparam logic [3:0] BLANK_LAST = 4'(BLANK_CYC - 1);

  state_t                state;
  logic [PRESCALE_W-1:0] cnt;
  logic [PRESCALE_W-1:0] div_reg;
  logic [PRESCALE_W-1:0] pend_val;
  logic                  pend_valid;
  logic [3:0]            blank_cnt;

  logic                  tick_evt;
  logic                  do_apply;
  logic [PRESCALE_W-1:0] apply_val;
  logic [SEL_W-1:0]      idle_pick;
  logic [SEL_W-1:0]      run_pick;

  // Lowest set index of the mask (0 when the mask is empty).
  function automatic logic [SEL_W-1:0] first_set(input logic [NUM_DIGITS-1:0] mask);
    logic [SEL_W-1:0] res;
    res = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      if (mask[i]) res = SEL_W'(i);
    end
    return res;
  endfunction

  // Next set index strictly after cur, wrapping to the lowest set index.
  function automatic logic [SEL_W-1:0] next_set(input logic [SEL_W-1:0]      cur,
                                                input logic [NUM_DIGITS-1:0] mask);
    logic [SEL_W-1:0] fwd_idx;
    logic             fwd_found;
    fwd_idx   = '0;
    fwd_found = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      if (mask[i] && (SEL_W'(i) > cur)) begin
        fwd_idx   = SEL_W'(i);
        fwd_found = 1'b1;
      end
    end
    return fwd_found ? fwd_idx : first_set(mask);
  endfunction

  // Active-low anode pattern that lights only digit idx.
  function automatic logic [NUM_DIGITS-1:0] show_mask(input logic [SEL_W-1:0] idx);
    logic [NUM_DIGITS-1:0] one;
    one = '0;
    one[0] = 1'b1;
    return ~(one << idx);
  endfunction

  // A divisor change lands on a tick, or straight away while the block is
  // paused; a load request in that same cycle wins over the older pending one.
  assign tick_evt  = en && (cnt == div_reg);
  assign do_apply  = (pend_valid || div_load) && (tick_evt || !en);
  assign apply_val = div_load ? div_in : pend_val;
  assign idle_pick = first_set(digit_en);
  assign run_pick  = next_set(sel, digit_en);

  // Prescaler, divisor handshake and the digit scheduling state machine.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      div_reg    <= DEFAULT_DIV;
      pend_val   <= '0;
      pend_valid <= 1'b0;
      blank_cnt  <= '0;
      sel        <= '0;
      anode      <= '1;
      tick       <= 1'b0;
      frame      <= 1'b0;
      div_ack    <= 1'b0;
    end else begin
      if (do_apply) begin
        div_reg    <= apply_val;
        pend_valid <= 1'b0;
      end else if (div_load) begin
        pend_val   <= div_in;
        pend_valid <= 1'b1;
      end
      div_ack <= do_apply;

      if (en) begin
        tick  <= tick_evt;
        frame <= 1'b0;
        if (tick_evt || do_apply) cnt <= '0;
        else                      cnt <= cnt + 1'b1;

        if (digit_en == '0) begin
          state <= IDLE;
          anode <= '1;
        end else if (tick_evt) begin
          if (state == IDLE) begin
            sel <= idle_pick;
          end else begin
            sel   <= run_pick;
            frame <= (run_pick <= sel);
          end
          if (BLANK_CYC == 0) begin
            state <= SHOW;
            anode <= show_mask((state == IDLE) ? idle_pick : run_pick);
          end else begin
            state     <= BLANK;
            blank_cnt <= BLANK_LAST;
            anode     <= '1;
          end
        end else begin
          case (state)
            IDLE: begin
              anode <= '1;
            end
            BLANK: begin
              if (blank_cnt != '0) begin
                blank_cnt <= blank_cnt - 1'b1;
              end else if (digit_en[sel]) begin
                state <= SHOW;
                anode <= show_mask(sel);
              end else begin
                anode <= '1;
              end
            end
            SHOW: begin
              if (!digit_en[sel]) begin
                state     <= BLANK;
                blank_cnt <= '0;
                anode     <= '1;
              end
            end
            default: begin
              state <= IDLE;
              anode <= '1;
            end
          endcase
        end
      end else if (do_apply) begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_seg_refresh_scheduler.sv
// tb_seg_refresh_scheduler
// Directed bench for seg_refresh_scheduler with four digits and two blank
// cycles. Expected tick results are queued as stimulus is applied and
// popped as the scheduler produces each tick.
module tb_seg_refresh_scheduler;

  localparam int NUM_DIGITS = 4;
  localparam int SEL_W      = 2;
  localparam int PRESCALE_W = 20;
  localparam int BLANK_CYC  = 2;

  logic                  clk;
  logic                  rst;
  logic                  en;
  logic [NUM_DIGITS-1:0] digit_en;
  logic [PRESCALE_W-1:0] div_in;
  logic                  div_load;
  logic                  div_ack;
  logic [SEL_W-1:0]      sel;
  logic [NUM_DIGITS-1:0] anode;
  logic                  tick;
  logic                  frame;

  typedef struct packed {
    logic [1:0] sel;
    logic       frame;
    logic       show;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;
  int   last_tick   = 0;
  int   exp_gap     = 4;

  seg_refresh_scheduler #(
    .NUM_DIGITS (NUM_DIGITS),
    .PRESCALE_W (PRESCALE_W),
    .BLANK_CYC  (BLANK_CYC)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .digit_en (digit_en),
    .div_in   (div_in),
    .div_load (div_load),
    .div_ack  (div_ack),
    .sel      (sel),
    .anode    (anode),
    .tick     (tick),
    .frame    (frame)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle counter used to measure tick spacing.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic                  en_v,
                               input logic [NUM_DIGITS-1:0] den_v,
                               input logic                  load_v,
                               input logic [PRESCALE_W-1:0] div_v);
    en       = en_v;
    digit_en = den_v;
    div_load = load_v;
    div_in   = div_v;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic wait_tick(input int budget, output logic ok);
    int n;
    n  = 0;
    ok = 1'b0;
    while (!ok && n < budget) begin
      step(1);
      n++;
      if (tick === 1'b1) ok = 1'b1;
    end
  endtask

  // Pops one expectation per tick; for displayed ticks it also follows the
  // blank window into the lit digit.
  task automatic run_ticks(input int n);
    exp_t       e;
    logic       ok;
    logic [3:0] exp_an;
    for (int k = 0; k < n; k++) begin
      e = sb.pop_front();
      wait_tick(40, ok);
      checkOutput("tick_seen", {31'd0, ok}, 32'd1);
      checkOutput("tick_gap", cyc - last_tick, exp_gap);
      last_tick = cyc;
      checkOutput("tick_sel", {30'd0, sel}, {30'd0, e.sel});
      checkOutput("tick_frame", {31'd0, frame}, {31'd0, e.frame});
      checkOutput("tick_anode_blank", {28'd0, anode}, 32'hF);
      if (e.show) begin
        step(1);
        checkOutput("blank2_anode", {28'd0, anode}, 32'hF);
        checkOutput("blank2_tick", {31'd0, tick}, 32'd0);
        checkOutput("blank2_frame", {31'd0, frame}, 32'd0);
        step(1);
        exp_an = ~(4'b0001 << e.sel);
        checkOutput("show_anode", {28'd0, anode}, {28'd0, exp_an});
      end
    end
  endtask

  initial begin
    int tick_hits;
    int ack_hits;

    // Reset
    rst = 1'b1;
    applyStimulus(1'b0, 4'b0000, 1'b0, '0);
    step(2);
    checkOutput("rst_sel", {30'd0, sel}, 32'd0);
    checkOutput("rst_anode", {28'd0, anode}, 32'hF);
    checkOutput("rst_tick", {31'd0, tick}, 32'd0);
    checkOutput("rst_frame", {31'd0, frame}, 32'd0);
    checkOutput("rst_div_ack", {31'd0, div_ack}, 32'd0);
    rst = 1'b0;

    // Load divisor 3 while paused: acknowledged the next cycle
    applyStimulus(1'b0, 4'b0000, 1'b1, 20'd3);
    step(1);
    checkOutput("load3_ack", {31'd0, div_ack}, 32'd1);
    applyStimulus(1'b0, 4'b0000, 1'b0, '0);
    step(1);
    checkOutput("load3_ack_clear", {31'd0, div_ack}, 32'd0);

    // All four digits in round-robin
    $display("[TB] round robin over 4'b1111");
    applyStimulus(1'b1, 4'b1111, 1'b0, '0);
    last_tick = cyc;
    exp_gap   = 4;
    sb.push_back('{sel: 2'd0, frame: 1'b0, show: 1'b1});
    sb.push_back('{sel: 2'd1, frame: 1'b0, show: 1'b1});
    sb.push_back('{sel: 2'd2, frame: 1'b0, show: 1'b1});
    sb.push_back('{sel: 2'd3, frame: 1'b0, show: 1'b1});
    sb.push_back('{sel: 2'd0, frame: 1'b1, show: 1'b1});
    run_ticks(5);

    // Sparse mask 1010
    $display("[TB] sparse mask 4'b1010");
    applyStimulus(1'b1, 4'b1010, 1'b0, '0);
    sb.push_back('{sel: 2'd1, frame: 1'b0, show: 1'b1});
    sb.push_back('{sel: 2'd3, frame: 1'b0, show: 1'b1});
    sb.push_back('{sel: 2'd1, frame: 1'b1, show: 1'b1});
    sb.push_back('{sel: 2'd3, frame: 1'b0, show: 1'b1});
    run_ticks(4);

    // Single digit: frame on every tick
    $display("[TB] single digit 4'b0100");
    applyStimulus(1'b1, 4'b0100, 1'b0, '0);
    sb.push_back('{sel: 2'd2, frame: 1'b1, show: 1'b1});
    sb.push_back('{sel: 2'd2, frame: 1'b1, show: 1'b1});
    sb.push_back('{sel: 2'd2, frame: 1'b1, show: 1'b1});
    run_ticks(3);

    // Divisor 0 loaded mid-period: applied at the next tick
    $display("[TB] divisor 0 mid-period");
    applyStimulus(1'b1, 4'b0100, 1'b1, 20'd0);
    step(1);
    checkOutput("div0_no_early_ack", {31'd0, div_ack}, 32'd0);
    applyStimulus(1'b1, 4'b0100, 1'b0, '0);
    sb.push_back('{sel: 2'd2, frame: 1'b1, show: 1'b0});
    run_ticks(1);
    checkOutput("div0_ack", {31'd0, div_ack}, 32'd1);
    exp_gap = 1;
    for (int i = 0; i < 4; i++) sb.push_back('{sel: 2'd2, frame: 1'b1, show: 1'b0});
    run_ticks(4);
    checkOutput("div0_ack_clear", {31'd0, div_ack}, 32'd0);

    // Back to divisor 3 while paused
    applyStimulus(1'b0, 4'b0100, 1'b1, 20'd3);
    step(1);
    checkOutput("reload3_ack", {31'd0, div_ack}, 32'd1);
    applyStimulus(1'b0, 4'b0100, 1'b0, '0);
    step(1);
    checkOutput("reload3_ack_clear", {31'd0, div_ack}, 32'd0);
    applyStimulus(1'b1, 4'b0100, 1'b0, '0);
    last_tick = cyc;
    exp_gap   = 4;
    sb.push_back('{sel: 2'd2, frame: 1'b1, show: 1'b1});
    run_ticks(1);

    // All digits disabled during SHOW
    $display("[TB] digit_en dropped to zero");
    applyStimulus(1'b1, 4'b0000, 1'b0, '0);
    step(1);
    checkOutput("off_anode", {28'd0, anode}, 32'hF);
    checkOutput("off_sel", {30'd0, sel}, 32'd2);
    step(1);
    checkOutput("off_anode_hold", {28'd0, anode}, 32'hF);
    checkOutput("off_sel_hold", {30'd0, sel}, 32'd2);
    checkOutput("off_frame", {31'd0, frame}, 32'd0);
    applyStimulus(1'b1, 4'b0001, 1'b0, '0);
    last_tick = cyc;
    sb.push_back('{sel: 2'd0, frame: 1'b0, show: 1'b1});
    run_ticks(1);

    // Pause for 10 cycles in the middle of the blank window
    $display("[TB] pause mid-blank");
    sb.push_back('{sel: 2'd0, frame: 1'b1, show: 1'b0});
    run_ticks(1);
    step(1);
    applyStimulus(1'b0, 4'b0001, 1'b0, '0);
    for (int i = 0; i < 10; i++) begin
      step(1);
      checkOutput("pause_anode", {28'd0, anode}, 32'hF);
      checkOutput("pause_sel", {30'd0, sel}, 32'd0);
      checkOutput("pause_tick", {31'd0, tick}, 32'd0);
      checkOutput("pause_frame", {31'd0, frame}, 32'd0);
    end
    applyStimulus(1'b1, 4'b0001, 1'b0, '0);
    last_tick = cyc;
    step(1);
    checkOutput("resume_anode", {28'd0, anode}, 32'hE);
    checkOutput("resume_tick", {31'd0, tick}, 32'd0);
    exp_gap = 3;
    sb.push_back('{sel: 2'd0, frame: 1'b1, show: 1'b1});
    run_ticks(1);

    // Reset during SHOW with a load pending
    $display("[TB] reset with pending load");
    applyStimulus(1'b1, 4'b0001, 1'b1, 20'd7);
    step(1);
    applyStimulus(1'b1, 4'b0001, 1'b0, '0);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    checkOutput("mid_rst_sel", {30'd0, sel}, 32'd0);
    checkOutput("mid_rst_anode", {28'd0, anode}, 32'hF);
    checkOutput("mid_rst_tick", {31'd0, tick}, 32'd0);
    checkOutput("mid_rst_frame", {31'd0, frame}, 32'd0);
    checkOutput("mid_rst_div_ack", {31'd0, div_ack}, 32'd0);
    checkOutput("mid_rst_div_reg", {12'd0, dut.div_reg}, 32'd99999);
    applyStimulus(1'b0, 4'b0001, 1'b0, '0);
    step(1);
    checkOutput("discard_ack_a", {31'd0, div_ack}, 32'd0);
    step(1);
    checkOutput("discard_ack_b", {31'd0, div_ack}, 32'd0);
    applyStimulus(1'b1, 4'b0001, 1'b0, '0);
    tick_hits = 0;
    ack_hits  = 0;
    for (int i = 0; i < 40; i++) begin
      step(1);
      if (tick === 1'b1)    tick_hits++;
      if (div_ack === 1'b1) ack_hits++;
    end
    checkOutput("default_div_no_tick", tick_hits, 32'd0);
    checkOutput("default_div_no_ack", ack_hits, 32'd0);
    checkOutput("default_div_anode", {28'd0, anode}, 32'hF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
